vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Free-running 640x480@60 Hz VGA timing generator; the stage directly upstream of the chessboard, piece and cursor renderers. Produces the DrawX/DrawY scan coordinates they consume, plus hsync/vsync/blank_n. These sync outputs are delayed by a configurable number of cycles so they line up with the renderers' registered RGB outputs at the connector. Also emits frame and line strobes and a frame counter for animation such as cursor blink.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, sync/blank delay in clocks; legal range 0..4
- vga_clk  in  1  pixel clock, 25 MHz; all state on posedge
- reset  in  1  asynchronous, active-high
- DrawX  out  10  horizontal count hc, 0..H_TOTAL-1
- DrawY  out  10  vertical count vc, 0..V_TOTAL-1
- active  out  1  undelayed: (hc < H_ACTIVE) && (vc < V_ACTIVE)
- line_start  out  1  undelayed: high for the one cycle where hc == 0
- frame_start  out  1  undelayed: high for the one cycle where hc == 0 && vc == 0
- frame_cnt  out  8  frames completed since reset, wraps 255->0
- hsync  out  1  active-low horizontal sync, delayed PIPE_DELAY clocks
- vsync  out  1  active-low vertical sync, delayed PIPE_DELAY clocks
- blank_n  out  1  display enable (= active), delayed PIPE_DELAY clocks

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525. Both must be ≤ 1024; out-of-range parameters are an elaboration error.
- Horizontal counter hc:
  - increments every clock;
  - at hc == H_TOTAL-1 the next value is 0.
- Vertical counter vc:
  - increments only on the clock where hc == H_TOTAL-1;
  - at vc == V_TOTAL-1 together with hc == H_TOTAL-1, the next value is 0.
- frame_cnt increments on that same wrap clock, i.e. in the same cycle frame_start next asserts.
- DrawX = hc and DrawY = vc, taken directly from registers, with no combinational path from inputs.
- Raw sync decode from the counters:
  - hs_raw = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751;
  - vs_raw = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- hs_raw, vs_raw and active pass through a PIPE_DELAY-deep shift register to produce hsync, vsync and blank_n.
  - PIPE_DELAY = 0: the outputs equal the raw decode.
  - Default 1: matches the renderers' one-clock registered RGB.
- Renderers treat DrawX ≥ 640 or DrawY ≥ 480 as off-screen. This block does not clamp the coordinates.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - hc, vc, frame_cnt = 0;
  - every delay stage is set to hsync=1, vsync=1, blank_n=0.
  - While reset is held: DrawX=0, DrawY=0, active=1, line_start=1, frame_start=1, hsync=1, vsync=1, blank_n=0.
- First posedge after reset release: hc advances to 1.
- Delayed outputs carry the undelayed value from PIPE_DELAY clocks earlier. During the first PIPE_DELAY clocks after release they show the reset fill values.
- Reset asserted mid-frame has the same effect as the reset above; there is no partial-frame recovery.
- Line period is 800 clocks. Frame period is 420000 clocks. hsync low lasts 96 clocks; vsync low lasts 1600 clocks.
- frame_start and line_start are single-cycle pulses. frame_start always coincides with a line_start.
- Boundary at hc == 799, vc == 524: on the next clock hc=0, vc=0, frame_cnt+1, frame_start=1.
- Wrap at frame_cnt == 255 goes to 0 with no flag.

## Test plan
- Reset release: hold reset 5 clocks, then release.
  - During reset: DrawX=0, DrawY=0, frame_start=1, hsync=1, vsync=1, blank_n=0.
  - With PIPE_DELAY=1: blank_n=1 from the second clock onward.
- Line wrap: run to DrawX=799, DrawY=10 → next clock DrawX=0, DrawY=11, line_start=1. line_start recurs exactly every 800 clocks.
- hsync alignment (PIPE_DELAY=1):
  - hsync is low exactly on the clocks where DrawX = 657..752; width 96.
  - blank_n falls on the clock where DrawX=641.
- Frame: frame_start period = 420000 clocks; frame_cnt increments once per frame_start.
  - vsync low while DrawY=490..491, with a one-clock lag from the delay stage; width 1600 clocks.
  - Run 256 frames: frame_cnt wraps to 0.
- Mid-frame reset: assert reset at DrawX=300, DrawY=200 between clock edges → outputs go to reset values immediately, before the next edge. After release, the full 420000-clock frame timing restarts from 0,0.
- Parameter sweep: PIPE_DELAY=0 → hsync low exactly when DrawX=656..751. PIPE_DELAY=3 → low at 659..754, and blank_n=0 for the first 3 clocks after reset release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: scan counters, line/frame strobes and a frame counter.
// Sync and blank are delayed so they line up with the renderers' registered RGB.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if ((PIPE_DELAY < 0) || (PIPE_DELAY > 4)) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be within 0..4");
    end
  endgenerate

  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic [7:0] frame_cnt_r;
  logic [9:0] hc_nxt_s;
  logic [9:0] vc_nxt_s;
  logic [7:0] frame_cnt_nxt_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic       active_s;

  // Raster advance: vc steps on the last pixel of a line, frame_cnt on the last pixel of a frame
  always_comb begin
    hc_nxt_s        = hc_r + 10'd1;
    vc_nxt_s        = vc_r;
    frame_cnt_nxt_s = frame_cnt_r;
    if (hc_r == H_LAST) begin
      hc_nxt_s = 10'd0;
      if (vc_r == V_LAST) begin
        vc_nxt_s        = 10'd0;
        frame_cnt_nxt_s = frame_cnt_r + 8'd1;
      end else begin
        vc_nxt_s = vc_r + 10'd1;
      end
    end else begin
      vc_nxt_s = vc_r;
    end
  end

  // Scan counter and frame counter registers
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_r        <= 10'd0;
      vc_r        <= 10'd0;
      frame_cnt_r <= 8'd0;
    end else begin
      hc_r        <= hc_nxt_s;
      vc_r        <= vc_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end

  // Raw decode of sync pulses and visible region from the counters
  always_comb begin
    hs_raw_s = !(({1'b0, hc_r} >= HS_BEGIN) && ({1'b0, hc_r} < HS_END));
    vs_raw_s = !(({1'b0, vc_r} >= VS_BEGIN) && ({1'b0, vc_r} < VS_END));
    active_s = ({1'b0, hc_r} < H_ACT_W) && ({1'b0, vc_r} < V_ACT_W);
  end

  assign DrawX       = hc_r;
  assign DrawY       = vc_r;
  assign frame_cnt   = frame_cnt_r;
  assign active      = active_s;
  assign line_start  = (hc_r == 10'd0);
  assign frame_start = (hc_r == 10'd0) && (vc_r == 10'd0);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hsync   = hs_raw_s;
      assign vsync   = vs_raw_s;
      assign blank_n = active_s;
    end else begin : g_delay
      // Each stage holds {hsync, vsync, blank_n}; reset fill is "sync idle, blanked"
      logic [2:0] pipe_r [PIPE_DELAY];

      // Alignment shift register for sync and blank
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            pipe_r[i] <= 3'b110;
          end
        end else begin
          pipe_r[0] <= {hs_raw_s, vs_raw_s, active_s};
          for (int i = 1; i < PIPE_DELAY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign {hsync, vsync, blank_n} = pipe_r[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instances for line timing and
// delay variants, a shrunken-raster instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Bench-side raster models: full 800x525 and small 16x8
  int mx, my, mf;
  int sx, sy, sf;

  logic [9:0] d1_x, d1_y, d0_x, d0_y, d3_x, d3_y, sm_x, sm_y;
  logic       d1_act, d1_ls, d1_fs, d1_hs, d1_vs, d1_bn;
  logic       d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_bn;
  logic       d3_act, d3_ls, d3_fs, d3_hs, d3_vs, d3_bn;
  logic       sm_act, sm_ls, sm_fs, sm_hs, sm_vs, sm_bn;
  logic [7:0] d1_fc, d0_fc, d3_fc, sm_fc;

  vga_timing_gen #(.PIPE_DELAY(1)) u_d1 (
    .vga_clk(clk), .reset(reset), .DrawX(d1_x), .DrawY(d1_y), .active(d1_act),
    .line_start(d1_ls), .frame_start(d1_fs), .frame_cnt(d1_fc),
    .hsync(d1_hs), .vsync(d1_vs), .blank_n(d1_bn));

  vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset(reset), .DrawX(d0_x), .DrawY(d0_y), .active(d0_act),
    .line_start(d0_ls), .frame_start(d0_fs), .frame_cnt(d0_fc),
    .hsync(d0_hs), .vsync(d0_vs), .blank_n(d0_bn));

  vga_timing_gen #(.PIPE_DELAY(3)) u_d3 (
    .vga_clk(clk), .reset(reset), .DrawX(d3_x), .DrawY(d3_y), .active(d3_act),
    .line_start(d3_ls), .frame_start(d3_fs), .frame_cnt(d3_fc),
    .hsync(d3_hs), .vsync(d3_vs), .blank_n(d3_bn));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(1)
  ) u_sm (
    .vga_clk(clk), .reset(reset), .DrawX(sm_x), .DrawY(sm_y), .active(sm_act),
    .line_start(sm_ls), .frame_start(sm_fs), .frame_cnt(sm_fc),
    .hsync(sm_hs), .vsync(sm_vs), .blank_n(sm_bn));

  task automatic model_reset();
    mx = 0; my = 0; mf = 0;
    sx = 0; sy = 0; sf = 0;
  endtask

  // One clock: advance the models on the edge, return at the following negedge
  task automatic tick();
    @(posedge clk);
    if (reset == 1'b0) begin
      if (mx == 799) begin
        mx = 0;
        if (my == 524) begin my = 0; mf = (mf + 1) % 256; end
        else my = my + 1;
      end else mx = mx + 1;
      if (sx == 15) begin
        sx = 0;
        if (sy == 7) begin sy = 0; sf = (sf + 1) % 256; end
        else sy = sy + 1;
      end else sx = sx + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    got = {d1_x == 10'd0, d1_y == 10'd0, d1_act, d1_ls, d1_fs, d1_fc == 8'd0,
           d1_hs, d1_vs, d1_bn, d3_hs, d3_bn, sm_x == 10'd0};
    exp = 12'b111111_110_101;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_values: got %b expected %b", got, exp);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (d1_x !== 10'(k) || sm_x !== 10'(k)) begin
        miscompares++;
        $display("FAIL release_drawx: clk %0d got %0d/%0d expected %0d", k, d1_x, sm_x, k);
      end
      vectors++;
      if (d1_bn !== (k >= 1) || d3_bn !== (k >= 3) || d0_bn !== 1'b1) begin
        miscompares++;
        $display("FAIL release_blank: clk %0d got d1=%b d3=%b d0=%b expected %b %b 1",
                 k, d1_bn, d3_bn, d0_bn, (k >= 1), (k >= 3));
      end
      tick();
    end
  endtask

  task automatic test_hsync();
    int low1, low3;
    logic e1, e0, e3, b1, b0, b3;
    low1 = 0; low3 = 0;
    for (int n = 0; n < 800; n++) begin
      e1 = !(mx >= 657 && mx <= 752);
      e0 = !(mx >= 656 && mx <= 751);
      e3 = !(mx >= 659 && mx <= 754);
      b1 = (mx >= 1 && mx <= 640);
      b0 = (mx < 640);
      b3 = (mx >= 3 && mx <= 642);
      vectors++;
      if (d1_x !== 10'(mx) || d1_y !== 10'(my) || d1_act !== b0) begin
        miscompares++;
        $display("FAIL hsync_coord: got x=%0d y=%0d act=%b expected x=%0d y=%0d act=%b",
                 d1_x, d1_y, d1_act, mx, my, b0);
      end
      vectors++;
      if (d1_hs !== e1 || d0_hs !== e0 || d3_hs !== e3) begin
        miscompares++;
        $display("FAIL hsync_level: x=%0d got d1=%b d0=%b d3=%b expected %b %b %b",
                 mx, d1_hs, d0_hs, d3_hs, e1, e0, e3);
      end
      vectors++;
      if (d1_bn !== b1 || d0_bn !== b0 || d3_bn !== b3) begin
        miscompares++;
        $display("FAIL blank_level: x=%0d got d1=%b d0=%b d3=%b expected %b %b %b",
                 mx, d1_bn, d0_bn, d3_bn, b1, b0, b3);
      end
      if (d1_hs == 1'b0) low1++;
      if (d3_hs == 1'b0) low3++;
      tick();
    end
    vectors++;
    if (low1 != 96 || low3 != 96) begin
      miscompares++;
      $display("FAIL hsync_width: got %0d/%0d expected 96", low1, low3);
    end
  endtask

  task automatic test_line_wrap();
    int n;
    while (!(mx == 799 && my == 10)) tick();
    vectors++;
    if (d1_x !== 10'd799 || d1_y !== 10'd10 || d1_ls !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_before: got x=%0d y=%0d ls=%b expected 799 10 0", d1_x, d1_y, d1_ls);
    end
    tick();
    vectors++;
    if (d1_x !== 10'd0 || d1_y !== 10'd11 || d1_ls !== 1'b1 || d1_fs !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_after: got x=%0d y=%0d ls=%b fs=%b expected 0 11 1 0",
               d1_x, d1_y, d1_ls, d1_fs);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (d1_ls !== 1'b1 && n < 1000);
    vectors++;
    if (n != 800) begin
      miscompares++;
      $display("FAIL line_period: got %0d expected 800", n);
    end
  endtask

  task automatic test_frame();
    int vlow, fs_seen, hp, vp;
    logic ev, eh, eb;
    while (!(sx == 0 && sy == 0)) tick();
    vlow = 0; fs_seen = 0;
    for (int n = 0; n < 256; n++) begin
      hp = (sx == 0) ? 15 : sx - 1;
      vp = (sx == 0) ? ((sy == 0) ? 7 : sy - 1) : sy;
      ev = !(vp >= 5 && vp <= 6);
      eh = !(hp >= 10 && hp <= 12);
      eb = (hp < 8) && (vp < 4);
      vectors++;
      if (sm_x !== 10'(sx) || sm_y !== 10'(sy) || sm_fc !== 8'(sf) ||
          sm_fs !== (sx == 0 && sy == 0) || sm_ls !== (sx == 0)) begin
        miscompares++;
        $display("FAIL frame_counters: got x=%0d y=%0d fc=%0d fs=%b ls=%b expected %0d %0d %0d",
                 sm_x, sm_y, sm_fc, sm_fs, sm_ls, sx, sy, sf);
      end
      vectors++;
      if (sm_vs !== ev || sm_hs !== eh || sm_bn !== eb) begin
        miscompares++;
        $display("FAIL frame_sync: x=%0d y=%0d got vs=%b hs=%b bn=%b expected %b %b %b",
                 sx, sy, sm_vs, sm_hs, sm_bn, ev, eh, eb);
      end
      if (sm_vs == 1'b0) vlow++;
      if (sm_fs == 1'b1) fs_seen++;
      tick();
    end
    vectors++;
    if (vlow != 64 || fs_seen != 2) begin
      miscompares++;
      $display("FAIL frame_totals: got vlow=%0d fs=%0d expected 64 2", vlow, fs_seen);
    end
  endtask

  task automatic test_frame_wrap();
    logic       saw_wrap;
    logic [7:0] prev;
    saw_wrap = 1'b0;
    prev = sm_fc;
    for (int n = 0; n < 256 * 128; n++) begin
      tick();
      if (sx == 0 && sy == 0) begin
        vectors++;
        if (sm_fc !== 8'(sf) || sm_fs !== 1'b1) begin
          miscompares++;
          $display("FAIL frame_cnt: got %0d fs=%b expected %0d 1", sm_fc, sm_fs, sf);
        end
        if (prev == 8'd255 && sm_fc == 8'd0) saw_wrap = 1'b1;
        prev = sm_fc;
      end
    end
    vectors++;
    if (saw_wrap !== 1'b1 || d1_fc !== 8'(mf) || d1_y !== 10'(my)) begin
      miscompares++;
      $display("FAIL frame_wrap: got wrap=%b fc=%0d y=%0d expected 1 %0d %0d",
               saw_wrap, d1_fc, d1_y, mf, my);
    end
  endtask

  task automatic test_mid_frame_reset();
    int n;
    while (mx != 300) tick();
    vectors++;
    if (d1_x !== 10'd300 || d1_y !== 10'(my)) begin
      miscompares++;
      $display("FAIL midreset_pre: got x=%0d y=%0d expected 300 %0d", d1_x, d1_y, my);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (d1_x !== 10'd0 || d1_y !== 10'd0 || d1_fs !== 1'b1 || d1_fc !== 8'd0 ||
        d1_hs !== 1'b1 || d1_vs !== 1'b1 || d1_bn !== 1'b0 || sm_fc !== 8'd0 || sm_x !== 10'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got x=%0d y=%0d fs=%b fc=%0d hs=%b vs=%b bn=%b smfc=%0d",
               d1_x, d1_y, d1_fs, d1_fc, d1_hs, d1_vs, d1_bn, sm_fc);
    end
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (sm_fs !== 1'b1 && n < 300);
    vectors++;
    if (n != 128 || sm_fc !== 8'd1) begin
      miscompares++;
      $display("FAIL midreset_frame: got period %0d fc=%0d expected 128 1", n, sm_fc);
    end
    while (n < 800) begin
      tick();
      n++;
    end
    vectors++;
    if (d1_x !== 10'd0 || d1_y !== 10'd1 || d1_ls !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_line: got x=%0d y=%0d ls=%b expected 0 1 1", d1_x, d1_y, d1_ls);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame();
    test_frame_wrap();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
